// File: rtl/mem_sequencer.sv
// mem_sequencer
//   Steps a single-cycle fetch/decode core through its accesses to one shared,
//   variable-latency memory port. For each instruction it fetches at pc, does
//   the optional load/store, then opens a one-cycle commit window (stall=0).
//   The core advances pc and writes back only in that window.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   pc                       core program counter, stable while stall=1
//   instruction              registered instruction word for the decoder
//   memRead/memWrite         decode: load / store (both set counts as a store)
//   dataAddr/dataWdata       data address and store data from the core
//   memSignWidth             funct3 width/sign code
//   dataRdata                registered raw load data
//   stall                    1 = hold pc and suppress writeback
//   memReq/memWe/memAddr     memory request, write enable, address
//   memWdata/memWidth        memory write data and width code
//   memAck/memRdata          memory completion and read data
//   busErr                   sticky bus-timeout flag
//   cycleCount/instret       free-running cycle and retired-instruction counters
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataWdata,
  input  logic [2:0]  memSignWidth,
  output logic [31:0] dataRdata,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [2:0]  memWidth,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        busErr,
  output logic [31:0] cycleCount,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {FETCH, EXEC, DATA, COMMIT} state_t;

  // Last value of the wait counter before the access is abandoned.
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  width_q;
  logic        we_q;
  logic        busErr_q;
  logic [31:0] cyc_q;
  logic [31:0] ret_q;
  logic [31:0] to_q;
  logic        to_hit;

  // Fires on the TIMEOUT-th consecutive unacknowledged request cycle.
  assign to_hit = (TIMEOUT != 0) && (to_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      instr_q  <= NOP;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      width_q  <= '0;
      we_q     <= 1'b0;
      busErr_q <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
      to_q     <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      case (state_q)
        FETCH: begin
          // An ack in the timeout cycle still completes the access cleanly.
          if (memAck) begin
            instr_q <= memRdata;
            state_q <= EXEC;
          end else if (to_hit) begin
            busErr_q <= 1'b1;
            instr_q  <= NOP;
            state_q  <= EXEC;
          end else begin
            to_q <= to_q + 32'd1;
          end
        end
        EXEC: begin
          // Decode has settled on the new instruction word this cycle.
          if (memRead || memWrite) begin
            addr_q  <= dataAddr;
            wdata_q <= dataWdata;
            width_q <= memSignWidth;
            we_q    <= memWrite;
            to_q    <= '0;
            state_q <= DATA;
          end else begin
            state_q <= COMMIT;
          end
        end
        DATA: begin
          if (memAck) begin
            if (!we_q) rdata_q <= memRdata;
            state_q <= COMMIT;
          end else if (to_hit) begin
            busErr_q <= 1'b1;
            rdata_q  <= '0;
            state_q  <= COMMIT;
          end else begin
            to_q <= to_q + 32'd1;
          end
        end
        COMMIT: begin
          ret_q   <= ret_q + 32'd1;
          to_q    <= '0;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Request and stall are decoded from state and gated by reset so that an
  // in-flight access is dropped in the very cycle reset asserts.
  assign memReq = rst && ((state_q == FETCH) || (state_q == DATA));
  assign stall  = !(rst && (state_q == COMMIT));

  always_comb begin
    memAddr  = '0;
    memWdata = '0;
    memWe    = 1'b0;
    memWidth = '0;
    case (state_q)
      FETCH: begin
        memAddr  = pc;
        memWidth = 3'b010;
      end
      DATA: begin
        memAddr  = addr_q;
        memWdata = wdata_q;
        memWe    = we_q;
        memWidth = width_q;
      end
      default: ;
    endcase
  end

  assign instruction = instr_q;
  assign dataRdata   = rdata_q;
  assign busErr      = busErr_q;
  assign cycleCount  = cyc_q;
  assign instret     = ret_q;

endmodule

// File: tb/tb_mem_sequencer.sv
module tb_mem_sequencer;
  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        memRead;
  logic        memWrite;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic [2:0]  memSignWidth;
  logic [31:0] dataRdata;
  logic        stall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [2:0]  memWidth;
  logic        memAck;
  logic [31:0] memRdata;
  logic        busErr;
  logic [31:0] cycleCount;
  logic [31:0] instret;

  int n_chk;
  int n_fail;
  logic [31:0] c0;

  mem_sequencer #(.TIMEOUT(4), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .memRead(memRead), .memWrite(memWrite), .dataAddr(dataAddr),
    .dataWdata(dataWdata), .memSignWidth(memSignWidth), .dataRdata(dataRdata),
    .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memWidth(memWidth), .memAck(memAck),
    .memRdata(memRdata), .busErr(busErr), .cycleCount(cycleCount),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; pc = '0; memRead = 0; memWrite = 0; dataAddr = '0;
    dataWdata = '0; memSignWidth = '0; memAck = 0; memRdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_rdata", dataRdata, 32'd0);
    chk("rst_busErr", 32'(busErr), 32'd0);
    chk("rst_cyc", cycleCount, 32'd0);
    chk("rst_instret", instret, 32'd0);

    // ALU instruction, zero-wait memory: 3 cycles
    rst = 1'b1; pc = 32'd0; memAck = 1; memRdata = 32'h0050_0093;
    #1;
    chk("f1_memReq", 32'(memReq), 32'd1);
    chk("f1_memAddr", memAddr, 32'd0);
    chk("f1_memWidth", 32'(memWidth), 32'd2);
    chk("f1_stall", 32'(stall), 32'd1);
    tick();
    memAck = 0;
    chk("e1_instr", instruction, 32'h0050_0093);
    chk("e1_memReq", 32'(memReq), 32'd0);
    chk("e1_stall", 32'(stall), 32'd1);
    tick();
    chk("c1_stall", 32'(stall), 32'd0);
    chk("c1_cyc", cycleCount, 32'd2);
    pc = 32'd4;
    tick();
    chk("c1_instret", instret, 32'd1);
    chk("f2_memAddr", memAddr, 32'd4);
    chk("f2_stall", 32'(stall), 32'd1);

    // Load with two wait cycles: 6 cycles
    c0 = cycleCount;
    memAck = 1; memRdata = 32'h0000_A103;
    tick();
    memAck = 0; memRead = 1; dataAddr = 32'h100; memSignWidth = 3'b010;
    tick();
    memRead = 0; dataAddr = '0;
    #1;
    chk("ld_memReq", 32'(memReq), 32'd1);
    chk("ld_memAddr", memAddr, 32'h100);
    chk("ld_memWe", 32'(memWe), 32'd0);
    chk("ld_memWidth", 32'(memWidth), 32'd2);
    tick(); tick();
    chk("ld_wait_req", 32'(memReq), 32'd1);
    memAck = 1; memRdata = 32'hDEAD_BEEF;
    tick();
    memAck = 0;
    chk("ld_rdata", dataRdata, 32'hDEAD_BEEF);
    chk("ld_stall", 32'(stall), 32'd0);
    chk("ld_cycles", cycleCount - c0, 32'd5);
    pc = 32'd8;
    tick();

    // Store byte
    memAck = 1; memRdata = 32'h00A1_0023;
    tick();
    memAck = 0; memWrite = 1; dataAddr = 32'h200; dataWdata = 32'h1234_5678;
    memSignWidth = 3'b000;
    tick();
    memWrite = 0;
    #1;
    chk("st_memWe", 32'(memWe), 32'd1);
    chk("st_memWidth", 32'(memWidth), 32'd0);
    chk("st_memWdata", memWdata, 32'h1234_5678);
    chk("st_memAddr", memAddr, 32'h200);
    memAck = 1; memRdata = 32'hCAFE_F00D;
    tick();
    memAck = 0;
    chk("st_rdata_keep", dataRdata, 32'hDEAD_BEEF);
    chk("st_stall", 32'(stall), 32'd0);
    pc = 32'hC;
    tick();
    chk("st_instret", instret, 32'd3);

    // Fetch timeout after 4 unacknowledged cycles
    memAck = 0; memRdata = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    chk("to_pre_busErr", 32'(busErr), 32'd0);
    chk("to_pre_req", 32'(memReq), 32'd1);
    tick();
    chk("to_busErr", 32'(busErr), 32'd1);
    chk("to_instr", instruction, 32'h0000_0013);
    chk("to_memReq", 32'(memReq), 32'd0);
    tick();
    chk("to_commit", 32'(stall), 32'd0);
    pc = 32'h10;
    tick();
    chk("to_next_addr", memAddr, 32'h10);
    chk("to_instret", instret, 32'd4);

    // Reset asserted during a DATA wait
    memAck = 1; memRdata = 32'h0000_A103;
    tick();
    memAck = 0; memRead = 1; dataAddr = 32'h300;
    tick();
    memRead = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("rd_memReq", 32'(memReq), 32'd0);
    chk("rd_stall", 32'(stall), 32'd1);
    chk("rd_instr", instruction, 32'h0000_0013);
    chk("rd_busErr", 32'(busErr), 32'd0);
    chk("rd_cyc", cycleCount, 32'd0);
    tick();
    rst = 1'b1; pc = 32'd0;
    #1;
    chk("rr_memReq", 32'(memReq), 32'd1);
    chk("rr_memAddr", memAddr, 32'd0);
    chk("rr_instret", instret, 32'd0);

    // Ack on the timeout cycle wins: no error
    tick(); tick(); tick();
    memAck = 1; memRdata = 32'h0050_0093;
    tick();
    memAck = 0;
    chk("ackwin_busErr", 32'(busErr), 32'd0);
    chk("ackwin_instr", instruction, 32'h0050_0093);
    chk("ackwin_cyc", cycleCount, 32'd4);

    // Cycle counter wrap
    force dut.cyc_q = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_q;
    chk("wrap_pre", cycleCount, 32'hFFFF_FFFE);
    tick();
    chk("wrap_0", cycleCount, 32'hFFFF_FFFF);
    tick();
    chk("wrap_1", cycleCount, 32'h0000_0000);
    tick();
    chk("wrap_2", cycleCount, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
